booth_issue: RTL
================

// Module: booth_issue
// PURPOSE
// - Operand-issue and result-capture stage wrapped around the booth multiplier.
// - Buffers incoming operand pairs in a DEPTH-entry FIFO and issues one pair at a time.
//   Each issue holds Mul_Mplier/Mul_Mcand stable and pulses Mul_Start.
// - Captures Mul_Product on Mul_Done and presents it on a valid/ready output port.
// - Decouples upstream producers and downstream consumers from the multiplier's multi-cycle latency.
// PARAMETERS
// - N      8   operand width; product width is 2N; must match the multiplier's N
// - DEPTH  4   operand FIFO entries; power of two, >= 2
// PORTS
// - Clock        in   1     rising-edge clock
// - Resetn       in   1     asynchronous active-low reset
// - In_Valid     in   1     operand pair valid
// - In_Ready     out  1     FIFO can accept a pair
// - In_Mplier    in   N     multiplier operand, two's complement
// - In_Mcand     in   N     multiplicand operand, two's complement
// - Out_Valid    out  1     Out_Product holds a finished result
// - Out_Ready    in   1     downstream accepts the result
// - Out_Product  out  2N    captured signed product
// - Mul_Start    out  1     one-cycle start pulse to the multiplier
// - Mul_Mplier   out  N     registered operand to the multiplier
// - Mul_Mcand    out  N     registered operand to the multiplier
// - Mul_Done     in   1     multiplier completion flag
// - Mul_Product  in   2N    multiplier result
// BEHAVIOUR
// - Reset (async, Resetn=0): FIFO empty, state IDLE.
//   - In_Ready=1, Out_Valid=0, Mul_Start=0; Out_Product, Mul_Mplier and Mul_Mcand are 0.
//   - Reset mid-operation discards all queued and in-flight work. No result is emitted.
// - Push: when In_Valid && In_Ready; In_Ready = !full.
//   - Full is a registered status; there is no push-when-full even if a pop occurs in the same cycle.
// - Pop: only in IDLE with FIFO non-empty.
//   - The head pair is registered into Mul_Mplier/Mul_Mcand.
//   - A simultaneous push and pop is legal and leaves the FIFO count unchanged.
// - FSM (state registered):
//   - IDLE:  if !empty, pop and go to START. Otherwise stay in IDLE.
//   - START: Mul_Start=1 for exactly this cycle, then go to ARM.
//   - ARM:   guard cycle. Mul_Done is ignored here, to mask a stale Done from the previous operation. Go to WAIT.
//   - WAIT:  on Mul_Done=1, register Mul_Product into Out_Product, set Out_Valid=1, and go to HOLD.
//   - HOLD:  Out_Valid=1. On Out_Ready=1, clear Out_Valid next cycle and go to IDLE.
// - Issue rules:
//   - Mul_Mplier and Mul_Mcand stay constant from START until the next pop.
//   - No new Start is issued while a result is unaccepted (HOLD), so output backpressure stalls issue.
// - Latency:
//   - Push to Mul_Start, with the FIFO previously empty and in IDLE: 2 cycles.
//     The head becomes visible the cycle after the push, the pop happens in IDLE, and START follows.
//   - Mul_Done to Out_Valid: 1 cycle.
//   - Throughput: one result per (multiplier latency + 4) cycles when Out_Ready is held high.
// - FIFO pointers: log2(DEPTH)+1 bits, wrap modulo 2*DEPTH.
//   - full: MSBs differ and LSBs are equal.
//   - empty: pointers are equal.
// - Arithmetic: no transformation. Out_Product is bit-exact to Mul_Product; signed interpretation belongs to the consumer.
// - Out_Product holds its value after acceptance until the next capture.
// STRUCTURE
// - Shared package booth_pkg:
//   - state encoding constants: IDLE=3'd0, START=3'd1, ARM=3'd2, WAIT=3'd3, HOLD=3'd4
//   - default N
// - Sub-module booth_fifo: synchronous FIFO, parameters W (=2N) and DEPTH.
//   - ports: Clock, Resetn, push, pop, wdata, rdata, full, empty
//   - data is read from the registered head (first-word-fall-through).
// - Top level: FSM, operand registers, result register. The booth multiplier is instantiated alongside, not inside.
// TESTING
// - Bench pairs booth_issue with the booth multiplier (N=8) and a scoreboard.
// - Single op: push (3,5) -> Mul_Start pulses once; Out_Valid rises with Out_Product=16'h000F.
// - Signed: push (8'hFE, 8'h07) -> Out_Product=16'hFFF2. Push (8'h80, 8'h80) -> 16'h4000.
// - Fill: hold Out_Ready=0 and push 5 pairs back-to-back.
//   - The first pair issues.
//   - After 4 more are queued, In_Ready=0 and the 6th In_Valid is not accepted.
//   - Release Out_Ready: all 5 products appear in order.
// - Backpressure: Out_Ready=0 for 20 cycles in HOLD -> Out_Valid and Out_Product stable, and no Mul_Start pulse.
// - Stale Done: a multiplier that holds Done high after finishing, then 2 queued ops -> each op waits for its own Done.
//   No duplicate or early capture.
// - Reset in WAIT: assert Resetn=0 mid-multiply -> Out_Valid=0, In_Ready=1 immediately.
//   After release, a fresh push (4,4) yields 16'h0010 only.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the booth multiplier issue stage: default operand width and FSM encoding.
package booth_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ARM   = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/booth_fifo.sv
// Synchronous first-word-fall-through FIFO holding packed operand pairs.
module booth_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/booth_issue.sv
// Operand-issue and result-capture stage that sits beside the booth multiplier.
//
// state | meaning
// IDLE  | waiting for a queued pair; pops the head into the operand registers
// START | one-cycle start pulse to the multiplier
// ARM   | guard cycle, a Done left over from the previous operation is ignored
// WAIT  | multiplier busy; Done captures the product
// HOLD  | result presented until the consumer accepts it
module booth_issue
  import booth_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic           Clock,
  input  logic           Resetn,
  input  logic           In_Valid,
  output logic           In_Ready,
  input  logic [N-1:0]   In_Mplier,
  input  logic [N-1:0]   In_Mcand,
  output logic           Out_Valid,
  input  logic           Out_Ready,
  output logic [2*N-1:0] Out_Product,
  output logic           Mul_Start,
  output logic [N-1:0]   Mul_Mplier,
  output logic [N-1:0]   Mul_Mcand,
  input  logic           Mul_Done,
  input  logic [2*N-1:0] Mul_Product
);

  state_t         state;
  state_t         state_next;
  logic [2*N-1:0] head;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic           capture;

  assign In_Ready = !full;
  assign push     = In_Valid && In_Ready;

  booth_fifo #(
    .W     (2*N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clock  (Clock),
    .Resetn (Resetn),
    .push   (push),
    .pop    (pop),
    .wdata  ({In_Mplier, In_Mcand}),
    .rdata  (head),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    Mul_Start  = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        Mul_Start  = 1'b1;
        state_next = ARM;
      end
      ARM:  state_next = WAIT;
      WAIT: begin
        if (Mul_Done) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (Out_Ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state       <= IDLE;
      Mul_Mplier  <= '0;
      Mul_Mcand   <= '0;
      Out_Product <= '0;
      Out_Valid   <= 1'b0;
    end else begin
      state <= state_next;
      // Operands stay frozen from the pop until the next pop.
      if (pop) begin
        Mul_Mplier <= head[2*N-1:N];
        Mul_Mcand  <= head[N-1:0];
      end
      if (capture) begin
        Out_Product <= Mul_Product;
        Out_Valid   <= 1'b1;
      end else if (state == HOLD && Out_Ready) begin
        Out_Valid <= 1'b0;
      end
    end
  end

endmodule
